// File: rtl/ulpi_reg_arbiter.sv
// ulpi_reg_arbiter
// -----------------------------------------------------------------------------
// Round-robin arbiter and sequencer for the single ULPI PHY register-access
// port. NREQ clients (chirp/enumeration FSM, debug readback, packet engine...)
// post requests; one is granted at a time, its fields are latched, a one-cycle
// REG_EN pulse is issued, and completion (or a timeout / READY loss) is turned
// into a one-cycle per-requester done or fail pulse. Everything is in the
// CLK_60M domain and every output comes straight from a flop.
//
// Optional build macro: ULPI_ARB_RETRY_EN
//   defined   : a PHY REG_FAIL is retried up to MAX_RETRY times (same latched
//               fields, grant held); timeout and READY-drop are never retried.
//   undefined : no retry logic; the first REG_FAIL is reported directly.
//
// Parameters
//   NREQ        number of requesters (2..8)
//   TIMEOUT_CYC cycles allowed in WAIT before a forced fail (>= 2)
//   MAX_RETRY   reissues after a PHY REG_FAIL (retry build only)
//
// Ports
//   CLK_60M, NRST_A_USB        clock, asynchronous active-low reset
//   REQ_VALID/RW/ADDR/WDATA    requester side; requester i owns bit i,
//                              ADDR[6i+5:6i], WDATA[8i+7:8i]
//   REQ_GNT                    one-hot, grant through response cycle
//   REQ_DONE / REQ_FAIL        one-cycle response pulses
//   REQ_RDATA                  read data, updated only by successful reads
//   BUSY                       FSM is not in IDLE
//   READY                      ULPI block ready
//   REG_EN/RW/ADDR/DATA_I      register-access command to the ULPI block
//   REG_DATA_O/DONE/FAIL       register-access result from the ULPI block
//   DBG_STATE                  current FSM state (0 IDLE, 1 ISSUE, 2 WAIT,
//                              3 RESP) for checkers and debug
//
// Handshake: a requester raises REQ_VALID with stable fields and keeps them
// until REQ_GNT is seen; fields are captured on the grant edge only. Exactly
// one of REQ_DONE/REQ_FAIL pulses per grant (unless reset intervenes).
// -----------------------------------------------------------------------------
module ulpi_reg_arbiter #(
  parameter int NREQ        = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_RETRY   = 2
) (
  input  logic              CLK_60M,
  input  logic              NRST_A_USB,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [NREQ-1:0]   REQ_RW,
  input  logic [6*NREQ-1:0] REQ_ADDR,
  input  logic [8*NREQ-1:0] REQ_WDATA,
  output logic [NREQ-1:0]   REQ_GNT,
  output logic [NREQ-1:0]   REQ_DONE,
  output logic [NREQ-1:0]   REQ_FAIL,
  output logic [7:0]        REQ_RDATA,
  output logic              BUSY,
  input  logic              READY,
  output logic              REG_EN,
  output logic              REG_RW,
  output logic [5:0]        REG_ADDR,
  output logic [7:0]        REG_DATA_I,
  input  logic [7:0]        REG_DATA_O,
  input  logic              REG_DONE,
  input  logic              REG_FAIL,
  output logic [1:0]        DBG_STATE
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;   // pointer / index width
  localparam int SW = PW + 1;                          // room for ptr + offset
  localparam int TW = $clog2(TIMEOUT_CYC + 1);         // timeout counter width

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2 || MAX_RETRY < 0) begin : g_param_check
    $error("ulpi_reg_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr_q;      // round-robin search start
  logic [PW-1:0]   gnt_idx;    // index of the current grant
  logic [TW-1:0]   tmo_cnt;

  // ---------------------------------------------------------------------------
  // Round-robin selection: rotate REQ_VALID so the pointer lands on bit 0,
  // take the lowest set bit, then map the offset back to a requester index.
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] arb_rot;
  logic [SW-1:0]   arb_sum;
  logic            arb_found;
  logic [PW-1:0]   arb_sel;
  logic [NREQ-1:0] arb_sel_oh;
  logic            sel_rw;
  logic [5:0]      sel_addr;
  logic [7:0]      sel_wdata;

  always_comb begin
    arb_rot   = '0;
    arb_sum   = '0;
    arb_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (ptr_q == PW'(j)) arb_rot[k] = REQ_VALID[(j + k) % NREQ];
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!arb_found && arb_rot[k]) begin
        arb_found = 1'b1;
        arb_sum   = {1'b0, ptr_q} + SW'(k);
      end
    end
    if (arb_sum >= SW'(NREQ)) arb_sum = arb_sum - SW'(NREQ);
    arb_sel = arb_sum[PW-1:0];
  end

  always_comb begin
    arb_sel_oh = '0;
    sel_rw     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_sel == PW'(i)) begin
        arb_sel_oh[i] = 1'b1;
        sel_rw        = REQ_RW[i];
        sel_addr      = REQ_ADDR[i*6 +: 6];
        sel_wdata     = REQ_WDATA[i*8 +: 8];
      end
    end
  end

  logic grant_fire;
  assign grant_fire = (state == S_IDLE) && READY && arb_found;

  // ---------------------------------------------------------------------------
  // Retry bookkeeping. retry_ok gates the "reissue instead of fail" branch in
  // WAIT; in the plain build it is tied low so the branch disappears.
  // ---------------------------------------------------------------------------
  logic retry_ok;

`ifdef ULPI_ARB_RETRY_EN
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RCW-1:0] retry_cnt;

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      retry_cnt <= '0;
    end else if (grant_fire) begin
      retry_cnt <= '0;
    end else if (state == S_WAIT && !REG_DONE && REG_FAIL && retry_ok) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  assign retry_ok = (retry_cnt < RCW'(MAX_RETRY));
`else
  assign retry_ok = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Main sequencer. REG_EN, REQ_DONE and REQ_FAIL default low each cycle so
  // they can only ever be single-cycle pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state      <= S_IDLE;
      ptr_q      <= '0;
      gnt_idx    <= '0;
      tmo_cnt    <= '0;
      REQ_GNT    <= '0;
      REQ_DONE   <= '0;
      REQ_FAIL   <= '0;
      REQ_RDATA  <= '0;
      BUSY       <= 1'b0;
      REG_EN     <= 1'b0;
      REG_RW     <= 1'b0;
      REG_ADDR   <= '0;
      REG_DATA_I <= '0;
    end else begin
      REG_EN   <= 1'b0;
      REQ_DONE <= '0;
      REQ_FAIL <= '0;
      case (state)
        S_IDLE: begin
          if (grant_fire) begin
            gnt_idx    <= arb_sel;
            REQ_GNT    <= arb_sel_oh;
            REG_RW     <= sel_rw;
            REG_ADDR   <= sel_addr;
            REG_DATA_I <= sel_wdata;
            BUSY       <= 1'b1;
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          REG_EN  <= 1'b1;
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end

        S_WAIT: begin
          // Priority: PHY done, PHY fail, READY loss, timeout.
          if (REG_DONE) begin
            if (!REG_RW) REQ_RDATA <= REG_DATA_O;
            REQ_DONE <= REQ_GNT;
            state    <= S_RESP;
          end else if (REG_FAIL) begin
            if (retry_ok) begin
              state <= S_ISSUE;
            end else begin
              REQ_FAIL <= REQ_GNT;
              state    <= S_RESP;
            end
          end else if (!READY) begin
            REQ_FAIL <= REQ_GNT;
            state    <= S_RESP;
          end else if (tmo_cnt == TW'(TIMEOUT_CYC)) begin
            REQ_FAIL <= REQ_GNT;
            state    <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RESP: begin
          REQ_GNT <= '0;
          BUSY    <= 1'b0;
          if (gnt_idx == PW'(NREQ - 1)) ptr_q <= '0;
          else                          ptr_q <= gnt_idx + 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign DBG_STATE = state;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// tb_ulpi_reg_arbiter
// -----------------------------------------------------------------------------
// Bench for ulpi_reg_arbiter (NREQ=3, TIMEOUT_CYC=255, MAX_RETRY=2).
// A small PHY responder answers each REG_EN after phy_delay cycles with
// done / fail / silence; a monitor pops expected responses from exp_q and
// checks command fields at every REG_EN against the fields captured at grant.
// -----------------------------------------------------------------------------
module tb_ulpi_reg_arbiter;

  localparam int NREQ = 3;
  localparam int TMO  = 255;
  localparam int MAXR = 2;

  // ---------------- clock / reset ----------------
  logic CLK_60M    = 1'b0;
  logic NRST_A_USB = 1'b1;
  always #8 CLK_60M = ~CLK_60M;

  int cyc = 0;
  always @(posedge CLK_60M) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]   REQ_VALID = '0;
  logic [NREQ-1:0]   REQ_RW    = '0;
  logic [6*NREQ-1:0] REQ_ADDR  = '0;
  logic [8*NREQ-1:0] REQ_WDATA = '0;
  logic [NREQ-1:0]   REQ_GNT, REQ_DONE, REQ_FAIL;
  logic [7:0]        REQ_RDATA;
  logic              BUSY;
  logic              READY = 1'b0;
  logic              REG_EN, REG_RW;
  logic [5:0]        REG_ADDR;
  logic [7:0]        REG_DATA_I;
  logic [7:0]        REG_DATA_O;
  logic              REG_DONE, REG_FAIL;
  logic [1:0]        DBG_STATE;

  ulpi_reg_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .CLK_60M(CLK_60M), .NRST_A_USB(NRST_A_USB),
    .REQ_VALID(REQ_VALID), .REQ_RW(REQ_RW), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .REQ_GNT(REQ_GNT), .REQ_DONE(REQ_DONE), .REQ_FAIL(REQ_FAIL), .REQ_RDATA(REQ_RDATA),
    .BUSY(BUSY), .READY(READY),
    .REG_EN(REG_EN), .REG_RW(REG_RW), .REG_ADDR(REG_ADDR), .REG_DATA_I(REG_DATA_I),
    .REG_DATA_O(REG_DATA_O), .REG_DONE(REG_DONE), .REG_FAIL(REG_FAIL),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // response record: {requester index, fail flag, REQ_RDATA}
  function automatic logic [12:0] rec(input int idx, input logic fail, input logic [7:0] d);
    logic [3:0] i4;
    i4 = idx[3:0];
    return {i4, fail, d};
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({REQ_GNT, REQ_DONE, REQ_FAIL, REQ_RDATA, BUSY,
                REG_EN, REG_RW, REG_ADDR, REG_DATA_I, DBG_STATE});
  endfunction

  // ---------------- scoreboard state ----------------
  logic [12:0] exp_q[$];
  logic [7:0]  model_rdata = 8'h00;
  int          en_cyc_q[$];
  int          resp_cyc_q[$];
  int          en_count = 0;
  int          gnt_cyc = 0;
  logic        snap_rw = 1'b0;
  logic [5:0]  snap_addr = '0;
  logic [7:0]  snap_wdata = '0;

  // ---------------- PHY responder ----------------
  int         phy_delay    = 5;
  int         phy_silent_n = 0;
  int         phy_fail_n   = 0;
  logic [7:0] phy_rdata    = 8'h00;
  int         phy_resp_cyc = 0;

  initial begin
    REG_DONE   = 1'b0;
    REG_FAIL   = 1'b0;
    REG_DATA_O = 8'h3C;
    forever begin
      @(negedge CLK_60M);
      if (REG_EN === 1'b1) begin
        if (phy_silent_n > 0) begin
          phy_silent_n--;
        end else begin
          repeat (phy_delay) @(negedge CLK_60M);
          if (phy_fail_n > 0) begin
            phy_fail_n--;
            REG_FAIL = 1'b1;
          end else begin
            REG_DONE   = 1'b1;
            REG_DATA_O = phy_rdata;
          end
          phy_resp_cyc = cyc;
          @(negedge CLK_60M);
          REG_DONE   = 1'b0;
          REG_FAIL   = 1'b0;
          REG_DATA_O = 8'h3C;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic            prev_en  = 1'b0;
  logic [NREQ-1:0] prev_gnt = '0;

  always @(negedge CLK_60M) begin
    if (NRST_A_USB) begin
      if (REQ_GNT != '0 && prev_gnt == '0) begin
        int gi;
        gnt_cyc = cyc;
        check("gnt_onehot", $countones(REQ_GNT), 1);
        gi = oh_idx(REQ_GNT);
        if (gi >= 0) begin
          snap_rw    = REQ_RW[gi];
          snap_addr  = 6'(REQ_ADDR >> (gi * 6));
          snap_wdata = 8'(REQ_WDATA >> (gi * 8));
        end
      end
      if (REG_EN) begin
        en_count++;
        en_cyc_q.push_back(cyc);
        check("en_width", prev_en, 1'b0);
        check("en_busy", BUSY, 1'b1);
        check("en_rw", REG_RW, snap_rw);
        check("en_addr", REG_ADDR, snap_addr);
        check("en_data", REG_DATA_I, snap_wdata);
      end
      if (REQ_DONE != '0 || REQ_FAIL != '0) begin
        resp_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("resp_unexp", {REQ_DONE, REQ_FAIL}, '0);
        end else begin
          logic [12:0] e;
          e = exp_q.pop_front();
          check("resp_onehot", $countones(REQ_DONE | REQ_FAIL), 1);
          check("resp", rec(oh_idx(REQ_DONE | REQ_FAIL), |REQ_FAIL, REQ_RDATA), e);
          check("gnt_in_resp", REQ_GNT, REQ_DONE | REQ_FAIL);
        end
      end
    end
    prev_en  = REG_EN;
    prev_gnt = REQ_GNT;
  end

  // ---------------- driver tasks ----------------
  task automatic set_fields(input int idx, input logic rw, input logic [5:0] addr,
                            input logic [7:0] wdata);
    REQ_RW[idx]            = rw;
    REQ_ADDR[idx*6 +: 6]   = addr;
    REQ_WDATA[idx*8 +: 8]  = wdata;
  endtask

  task automatic wait_grant_drop(input int idx, input int limit);
    logic [NREQ-1:0] want;
    want = '0;
    want[idx] = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK_60M);
      if (REQ_GNT[idx]) begin
        REQ_VALID[idx] = 1'b0;
        return;
      end
    end
    check("gnt_wait", REQ_GNT, want);
    REQ_VALID[idx] = 1'b0;
  endtask

  task automatic wait_empty(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK_60M);
      #1;
      if (exp_q.size() == 0) return;
    end
    check("resp_wait", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_en(input int start, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK_60M);
      if (en_count > start) return;
    end
    check("en_wait", en_count, start + 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500us;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0, en0, rdy_cyc;

    // reset
    #3 NRST_A_USB = 1'b0;
    repeat (2) @(negedge CLK_60M);
    check("rst_outs", all_outs(), 64'h0);
    NRST_A_USB = 1'b1;
    @(negedge CLK_60M);
    check("rst_idle", DBG_STATE, 2'd0);
    READY = 1'b1;
    @(negedge CLK_60M);

    // single write: req0, ADDR 0x04, WDATA 0x65, PHY done 5 cycles after REG_EN
    phy_delay = 5;
    phy_rdata = 8'h5A;
    en0 = en_count;
    set_fields(0, 1'b1, 6'h04, 8'h65);
    REQ_VALID[0] = 1'b1;
    c0 = cyc;
    exp_q.push_back(rec(0, 1'b0, model_rdata));
    en_cyc_q.delete();
    resp_cyc_q.delete();
    wait_grant_drop(0, 10);
    wait_empty(40);
    check("t1_gnt_lat", gnt_cyc - c0, 1);
    check("t1_en_lat", en_cyc_q[0] - c0, 2);
    check("t1_resp_lat", resp_cyc_q[0] - phy_resp_cyc, 1);
    check("t1_en_cnt", en_count - en0, 1);
    check("t1_addr", REG_ADDR, 6'h04);
    check("t1_data", REG_DATA_I, 8'h65);
    @(negedge CLK_60M);
    check("t1_busy", BUSY, 1'b0);

    // read: req2, ADDR 0x16, PHY returns 0xA5
    phy_rdata   = 8'hA5;
    model_rdata = 8'hA5;
    set_fields(2, 1'b0, 6'h16, 8'hFF);
    REQ_VALID[2] = 1'b1;
    exp_q.push_back(rec(2, 1'b0, model_rdata));
    wait_grant_drop(2, 10);
    wait_empty(40);
    check("t2_rdata", REQ_RDATA, 8'hA5);

    // write by req2 afterwards: read data must hold; fields changed after
    // grant must not reach the PHY (monitor compares against grant snapshot)
    phy_rdata = 8'h5A;
    set_fields(2, 1'b1, 6'h21, 8'h33);
    REQ_VALID[2] = 1'b1;
    exp_q.push_back(rec(2, 1'b0, model_rdata));
    wait_grant_drop(2, 10);
    #2 set_fields(2, 1'b0, 6'h3F, 8'hEE);
    wait_empty(40);
    check("t3_rdata_hold", REQ_RDATA, 8'hA5);
    check("t3_addr_latched", REG_ADDR, 6'h21);

    // round robin: all three pending continuously, req1 reads
    phy_delay = 2;
    phy_rdata = 8'($urandom_range(0, 255));
    for (int i = 0; i < NREQ; i++)
      set_fields(i, (i != 1), 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
    en0 = en_count;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i == 1) model_rdata = phy_rdata;
        exp_q.push_back(rec(i, 1'b0, model_rdata));
      end
    end
    REQ_VALID = '1;
    wait_empty(200);
    REQ_VALID = '0;
    check("t4_en_cnt", en_count - en0, 6);

    // timeout on req0 while req1 waits; req1 then served
    phy_delay    = 3;
    phy_silent_n = 1;
    set_fields(0, 1'b1, 6'h0A, 8'h11);
    set_fields(1, 1'b1, 6'h0B, 8'h22);
    exp_q.push_back(rec(0, 1'b1, model_rdata));
    exp_q.push_back(rec(1, 1'b0, model_rdata));
    en_cyc_q.delete();
    resp_cyc_q.delete();
    REQ_VALID = 3'b011;
    wait_grant_drop(0, 10);
    wait_grant_drop(1, 400);
    wait_empty(40);
    check("t5_tmo_lat", resp_cyc_q[0] - en_cyc_q[0], TMO + 1);

    // PHY fails every attempt
    phy_fail_n = 3;
    en0 = en_count;
    set_fields(1, 1'b1, 6'h2C, 8'h44);
    REQ_VALID[1] = 1'b1;
    exp_q.push_back(rec(1, 1'b1, model_rdata));
    wait_grant_drop(1, 10);
    wait_empty(100);
`ifdef ULPI_ARB_RETRY_EN
    check("t6_en_cnt", en_count - en0, MAXR + 1);
`else
    check("t6_en_cnt", en_count - en0, 1);
`endif
    phy_fail_n = 0;

    // PHY fails once, then would succeed
    phy_fail_n = 1;
    en0 = en_count;
    set_fields(2, 1'b1, 6'h31, 8'h55);
    REQ_VALID[2] = 1'b1;
`ifdef ULPI_ARB_RETRY_EN
    exp_q.push_back(rec(2, 1'b0, model_rdata));
`else
    exp_q.push_back(rec(2, 1'b1, model_rdata));
`endif
    wait_grant_drop(2, 10);
    wait_empty(100);
`ifdef ULPI_ARB_RETRY_EN
    check("t7_en_cnt", en_count - en0, 2);
`else
    check("t7_en_cnt", en_count - en0, 1);
`endif
    phy_fail_n = 0;

    // READY drop during WAIT forces a fail one cycle later
    phy_silent_n = 1;
    en0 = en_count;
    set_fields(0, 1'b0, 6'h12, 8'h00);
    REQ_VALID[0] = 1'b1;
    exp_q.push_back(rec(0, 1'b1, model_rdata));
    resp_cyc_q.delete();
    wait_grant_drop(0, 10);
    wait_en(en0, 10);
    @(negedge CLK_60M);
    READY   = 1'b0;
    rdy_cyc = cyc;
    @(negedge CLK_60M);
    READY = 1'b1;
    wait_empty(20);
    check("t8_drop_lat", resp_cyc_q[0] - rdy_cyc, 1);

    // asynchronous reset during WAIT (pointer is 1 here), no response expected
    phy_silent_n = 1;
    en0 = en_count;
    set_fields(1, 1'b1, 6'h07, 8'h77);
    REQ_VALID[1] = 1'b1;
    wait_grant_drop(1, 10);
    wait_en(en0, 10);
    repeat (3) @(negedge CLK_60M);
    check("t9_in_wait", DBG_STATE, 2'd2);
    NRST_A_USB = 1'b0;
    #2;
    check("t9_rst_outs", all_outs(), 64'h0);
    @(negedge CLK_60M);
    model_rdata = 8'h00;
    READY       = 1'b0;
    NRST_A_USB  = 1'b1;
    REQ_VALID   = '1;
    repeat (8) @(negedge CLK_60M);
    check("t9_no_gnt", REQ_GNT, '0);
    check("t9_not_busy", BUSY, 1'b0);
    // pointer back at 0: order 0,1,2
    phy_delay = 1 + $urandom_range(0, 3);
    for (int i = 0; i < NREQ; i++) begin
      set_fields(i, 1'b1, 6'(8 + i), 8'(8'h90 + i));
      exp_q.push_back(rec(i, 1'b0, model_rdata));
    end
    READY = 1'b1;
    wait_empty(100);
    REQ_VALID = '0;
    repeat (4) @(negedge CLK_60M);
    check("end_idle", DBG_STATE, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
